instr_prefetch_buffer: RTL

Fetch-side front end for the RISC-V core. Generates sequential instruction-memory requests, absorbs variable-latency in-order responses, and queues instructions with their PC in a small FIFO. The decode/register-file stage consumes from the FIFO via a valid/ready handshake. A redirect input (branch/jump target) flushes queued and in-flight instructions and restarts fetch at the new PC.

---
 rtl/instr_prefetch_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches under a credit limit,
// queues in-order responses with their PC, and flushes on redirect.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [31:0]                imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [31:0]                imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;

  logic          rsp_ok;
  logic          credit;
  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Outstanding fetches include ones already marked for discard, so the credit
  // check alone bounds queued plus in-flight words to DEPTH.
  assign credit         = ({1'b0, occ_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_ok    = imem_rsp_valid && (outst_q != '0);
  assign push      = rsp_ok && (disc_q == '0) && !redirect_valid;
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign out_instr = instr_q[rptr_q];
  assign out_pc    = pc_q[rptr_q];
  assign occupancy = occ_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    occ_d      = occ_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      outst_d    = outst_q - CW'(rsp_ok);
      disc_d     = outst_q - CW'(rsp_ok);
      occ_d      = '0;
      rptr_d     = '0;
      wptr_d     = '0;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CW'(accept) - CW'(rsp_ok);
      if (rsp_ok) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      occ_q      <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      occ_q      <= occ_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      if (push) begin
        instr_q[wptr_q] <= imem_rsp_data;
        pc_q[wptr_q]    <= rsp_pc_q;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ_q == CW'(DEPTH))));

endmodule
